// File: rtl/led_pattern_gen_if.sv
// Control and LED-drive bundle for led_pattern_gen.
// The master modport is the controller side; the slave modport is the generator side.
interface led_pattern_gen_if #(
  parameter int LED_WIDTH = 32
);
  logic [1:0]           mode;
  logic                 pause;
  logic [LED_WIDTH-1:0] led;
  logic                 step_tick;
  logic [1:0]           active_mode;

  modport master (
    output mode,
    output pause,
    input  led,
    input  step_tick,
    input  active_mode
  );

  modport slave (
    input  mode,
    input  pause,
    output led,
    output step_tick,
    output active_mode
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary, gray, bouncing scan and PWM breathing patterns,
// advanced once per prescaler wrap. The requested mode is only sampled on a step.
module led_pattern_gen #(
  parameter int LED_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 24,
  parameter int PWM_BITS       = 8
) (
  input  logic             clk,
  input  logic             rst,
  led_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int                  POS_W    = $clog2(LED_WIDTH);
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(LED_WIDTH - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic [PWM_BITS-1:0]       r_pwm;
  logic [PWM_BITS-1:0]       r_duty;
  logic [PWM_BITS-1:0]       w_duty_nxt;
  logic                      r_falling;
  logic                      w_falling_nxt;
  logic [LED_WIDTH-1:0]      r_cnt;
  logic [LED_WIDTH-1:0]      w_cnt_nxt;
  logic [POS_W-1:0]          r_pos;
  logic [POS_W-1:0]          w_pos_nxt;
  logic                      r_dir_down;
  logic                      w_dir_down_nxt;
  mode_e                     r_mode;
  mode_e                     w_mode_nxt;
  mode_e                     w_req_mode;
  logic                      r_step_tick;
  logic                      w_tick;
  logic [LED_WIDTH-1:0]      w_led;

  function automatic logic [LED_WIDTH-1:0] gray_enc(input logic [LED_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_req_mode = mode_e'(bus.mode);
  assign w_tick     = (&r_pre) & ~bus.pause;

  // Next pattern state: a mode change on a step reinitialises instead of advancing
  always_comb begin
    w_mode_nxt     = r_mode;
    w_cnt_nxt      = r_cnt;
    w_pos_nxt      = r_pos;
    w_dir_down_nxt = r_dir_down;
    w_duty_nxt     = r_duty;
    w_falling_nxt  = r_falling;
    if (w_tick) begin
      if (w_req_mode != r_mode) begin
        w_mode_nxt     = w_req_mode;
        w_cnt_nxt      = '0;
        w_pos_nxt      = '0;
        w_dir_down_nxt = 1'b0;
        w_duty_nxt     = '0;
        w_falling_nxt  = 1'b0;
      end else begin
        unique case (r_mode)
          MODE_BIN, MODE_GRAY: begin
            w_cnt_nxt = r_cnt + LED_WIDTH'(1);
          end
          MODE_SCAN: begin
            if (!r_dir_down) begin
              if (r_pos == POS_MAX) begin
                w_dir_down_nxt = 1'b1;
                w_pos_nxt      = r_pos - POS_W'(1);
              end else begin
                w_pos_nxt = r_pos + POS_W'(1);
              end
            end else begin
              if (r_pos == '0) begin
                w_dir_down_nxt = 1'b0;
                w_pos_nxt      = POS_W'(1);
              end else begin
                w_pos_nxt = r_pos - POS_W'(1);
              end
            end
          end
          MODE_BREATHE: begin
            if (!r_falling) begin
              if (r_duty == DUTY_MAX) begin
                w_falling_nxt = 1'b1;
                w_duty_nxt    = r_duty - PWM_BITS'(1);
              end else begin
                w_duty_nxt = r_duty + PWM_BITS'(1);
              end
            end else begin
              if (r_duty == '0) begin
                w_falling_nxt = 1'b0;
                w_duty_nxt    = PWM_BITS'(1);
              end else begin
                w_duty_nxt = r_duty - PWM_BITS'(1);
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre       <= '0;
      r_pwm       <= '0;
      r_step_tick <= 1'b0;
      r_mode      <= MODE_BIN;
      r_cnt       <= '0;
      r_pos       <= '0;
      r_dir_down  <= 1'b0;
      r_duty      <= '0;
      r_falling   <= 1'b0;
    end else begin
      if (!bus.pause) begin
        r_pre <= r_pre + PRESCALE_WIDTH'(1);
      end
      r_pwm       <= r_pwm + PWM_BITS'(1);
      r_step_tick <= w_tick;
      r_mode      <= w_mode_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pos       <= w_pos_nxt;
      r_dir_down  <= w_dir_down_nxt;
      r_duty      <= w_duty_nxt;
      r_falling   <= w_falling_nxt;
    end
  end

  // LED decode uses registered state only, so mode/pause never reach the pins combinationally
  always_comb begin
    w_led = '0;
    unique case (r_mode)
      MODE_BIN:     w_led = r_cnt;
      MODE_GRAY:    w_led = gray_enc(r_cnt);
      MODE_SCAN:    w_led = LED_WIDTH'(1) << r_pos;
      MODE_BREATHE: w_led = {LED_WIDTH{r_pwm < r_duty}};
    endcase
  end

  assign bus.led         = w_led;
  assign bus.step_tick   = r_step_tick;
  assign bus.active_mode = r_mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen at LED_WIDTH=4, PRESCALE_WIDTH=2, PWM_BITS=3.
module tb_led_pattern_gen;

  localparam int LW = 4;
  localparam int PW = 2;
  localparam int PB = 3;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pattern_gen_if #(.LED_WIDTH(LW)) bus ();

  led_pattern_gen #(
    .LED_WIDTH      (LW),
    .PRESCALE_WIDTH (PW),
    .PWM_BITS       (PB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          sb_q[$];
  exp_t          mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  int            m_mode;
  int            m_k;
  logic [PB-1:0] tb_pwm;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected pattern value k steps after entering mode md (duty for breathe)
  function automatic logic [3:0] exp_val(input int md, input int k);
    int p;
    case (md)
      0: return 4'(k % 16);
      1: begin p = k % 16; return 4'(p ^ (p >> 1)); end
      2: begin p = k % 6;  return 4'(1 << ((p <= 3) ? p : 6 - p)); end
      default: begin p = k % 14; return 4'((p <= 7) ? p : 14 - p); end
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) tb_pwm <= '0;
    else      tb_pwm <= tb_pwm + 3'd1;
  end

  always @(negedge clk) begin
    if (rst && bus.step_tick) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_step", 32'(bus.led), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        chk("active_mode", 32'(bus.active_mode), 32'(mon_e.mode));
        if (mon_e.mode == 2'd3)
          chk("led_breathe", 32'(bus.led), 32'((tb_pwm < mon_e.val[2:0]) ? 4'hF : 4'h0));
        else
          chk("led", 32'(bus.led), 32'(mon_e.val));
      end
    end
  end

  task automatic do_step(input logic [1:0] m, output int lat);
    exp_t e;
    bus.mode = m;
    if (int'(m) != m_mode) begin
      m_mode = int'(m);
      m_k    = 0;
    end else begin
      m_k++;
    end
    e.mode = m;
    e.val  = exp_val(m_mode, m_k);
    sb_q.push_back(e);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.step_tick) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      chk("step_timeout", 32'(lat), 32'd4);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic measure(input int exp_lit);
    int lit;
    lit = 0;
    bus.pause = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("breathe_level", 32'((bus.led == 4'h0) || (bus.led == 4'hF)), 32'd1);
      if (bus.led == 4'hF) lit++;
    end
    chk("breathe_lit_count", 32'(lit), 32'(exp_lit));
    bus.pause = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         lat;
    logic [3:0] hold_led;
    rst       = 1'b0;
    bus.mode  = 2'd0;
    bus.pause = 1'b0;
    m_mode    = 0;
    m_k       = 0;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(bus.led), 32'd0);
    chk("reset_step_tick", 32'(bus.step_tick), 32'd0);
    chk("reset_active_mode", 32'(bus.active_mode), 32'd0);
    rst = 1'b1;

    // Binary: 1..15 then wrap to 0
    do_step(2'd0, lat);
    chk("first_tick_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 15; i++) do_step(2'd0, lat);
    chk("binary_step_period", 32'(lat), 32'd4);

    // Gray: switch shows 0, then 1,3,2,6,7,5,4,12
    for (int i = 0; i < 9; i++) do_step(2'd1, lat);

    // Scan, with a mode glitch between ticks that must be ignored
    for (int i = 0; i < 4; i++) do_step(2'd2, lat);
    bus.mode = 2'd1;
    @(negedge clk);
    bus.mode = 2'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) do_step(2'd2, lat);

    // Pause at pos=2 while toggling mode
    bus.pause = 1'b1;
    hold_led  = bus.led;
    chk("scan_pos2_before_pause", 32'(hold_led), 32'h4);
    for (int i = 0; i < 10; i++) begin
      bus.mode = 2'(i);
      @(negedge clk);
      chk("pause_led", 32'(bus.led), 32'(hold_led));
      chk("pause_step_tick", 32'(bus.step_tick), 32'd0);
      chk("pause_active_mode", 32'(bus.active_mode), 32'd2);
    end
    bus.pause = 1'b0;
    do_step(2'd2, lat);
    chk("pause_release_latency", 32'(lat), 32'd4);

    // Breathe: duty triangle 0..7..0,1 with PWM duty checks
    for (int i = 0; i < 4; i++) do_step(2'd3, lat);
    measure(3);
    for (int i = 0; i < 4; i++) do_step(2'd3, lat);
    measure(7);
    for (int i = 0; i < 7; i++) do_step(2'd3, lat);
    measure(0);
    do_step(2'd3, lat);

    // Asynchronous reset between edges during breathe
    do_step(2'd3, lat);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_led", 32'(bus.led), 32'd0);
    chk("async_reset_step_tick", 32'(bus.step_tick), 32'd0);
    chk("async_reset_active_mode", 32'(bus.active_mode), 32'd0);
    m_mode = 0;
    m_k    = 0;
    repeat (2) @(negedge clk);
    bus.mode = 2'd0;
    rst = 1'b1;
    do_step(2'd0, lat);
    chk("post_reset_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 2; i++) do_step(2'd0, lat);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LED_WIDTH, default 32, number of LED outputs driven; SHALL be >= 2.
REQ-002 Parameter PRESCALE_WIDTH, default 24, prescaler width; step period = 2^PRESCALE_WIDTH clk cycles; SHALL be >= 1.
REQ-003 Parameter PWM_BITS, default 8, breathing-mode duty/PWM resolution; SHALL be >= 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  2  requested pattern: 0 binary, 1 gray, 2 scan, 3 breathe.
REQ-007 pause  input  1  high freezes pattern stepping.
REQ-008 led  output  LED_WIDTH  LED drive, 1 = lit.
REQ-009 step_tick  output  1  one-cycle pulse, cycle after each pattern step.
REQ-010 active_mode  output  2  mode currently in effect.

Function
REQ-011 Prescaler pre counts up by 1 per clk while pause=0, wraps 2^PRESCALE_WIDTH-1 -> 0; holds while pause=1.
REQ-012 tick = (pre == all-ones) && pause==0; every pattern update SHALL occur only on a tick edge.
REQ-013 step_tick SHALL be registered: high exactly one cycle following each tick edge, else 0.
REQ-014 mode sampled only on tick edges; if mode != active_mode: active_mode <= mode and pattern state reinitialised (cnt=0, pos=0, dir=up, duty=0, rising) instead of advancing; step_tick still pulses.
REQ-015 mode changes between ticks SHALL have no effect; only the value present at the tick edge counts.
REQ-016 Binary (0): cnt increments mod 2^LED_WIDTH per tick; led = cnt; all-ones wraps to 0.
REQ-017 Gray (1): cnt increments as binary; led = cnt XOR (cnt >> 1); successive led values differ in exactly one bit, including at wrap.
REQ-018 Scan (2): led = one-hot at pos; pos bounces 0,1,...,LED_WIDTH-1,LED_WIDTH-2,...,0,1,...; period 2*LED_WIDTH-2 ticks; direction flips at ends without dwelling.
REQ-019 Breathe (3): duty ramps 0 -> 2^PWM_BITS-1 -> 0 one step per tick, triangle, no dwell at extremes.
REQ-020 Breathe PWM: pwm counter (PWM_BITS wide) free-runs every clk regardless of pause; all led bits = 1 when pwm < duty, else 0; duty=0 -> always dark; duty=max -> lit 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-021 led SHALL be a function of registered state only; no combinational path from mode or pause to led.
REQ-022 cnt, pos, duty share no meaning across modes; only the reinitialised state of REQ-014 applies after a switch.
REQ-023 pause held across a tick boundary: no step, no step_tick, no mode sampling until pre next reaches all-ones with pause=0.

Reset
REQ-024 rst=0 SHALL immediately (no clock) force: pre=0, pwm=0, cnt=0, pos=0, dir=up, duty=0 rising, active_mode=0, step_tick=0, led=0.
REQ-025 Reset release SHALL be the first cycle counted; first tick occurs 2^PRESCALE_WIDTH clk edges after release with pause=0.
REQ-026 Reset asserted mid-operation in any mode SHALL discard all state; no partial step completes.

Verification (LED_WIDTH=4, PRESCALE_WIDTH=2, PWM_BITS=3)
REQ-027 Reset, mode=0, pause=0 -> led steps 0,1,2,...,15,0 every 4 clk; step_tick one cycle after each step.
REQ-028 mode=1 at tick -> active_mode=1, led=0; next ticks 1,3,2,6,7,5,4,12.
REQ-029 mode=2 at tick -> led 0001; then 0010,0100,1000,0100,0010,0001,0010.
REQ-030 mode=3 -> duty 0,1,...,7,6,...,0,1; at duty=3 led=1111 for exactly 3 of each 8 clk, 0000 otherwise.
REQ-031 Scan at pos=2, pause=1 for 10 clk, mode toggled meanwhile -> led, pre, active_mode frozen, no step_tick; after release next step pos=3 (or switch if mode differs at that tick).
REQ-032 rst driven low between clock edges during breathe -> led=0000, active_mode=0, step_tick=0 before next edge; after release binary count restarts at 0.
